ball_kinematics: RTL and testbench

//  Per-ball motion engine for the billiards table: owns one ball's position, speed and direction.

---
 rtl/ball_kinematics_pkg.sv | 27 ++
 rtl/ball_kinematics_axis_stepper.sv | 76 +++++++
 rtl/ball_kinematics.sv | 92 +++++++++
 tb/tb_ball_kinematics.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_kinematics_pkg.sv
// Shared table geometry, speed limits and FSM encoding for the per-ball motion engine.
package ball_kinematics_pkg;

  localparam logic [9:0] BALL_SIZE    = 10'd30;
  localparam logic [9:0] TABLE_LEFT   = 10'd20;
  localparam logic [9:0] TABLE_RIGHT  = 10'd620;
  localparam logic [9:0] TABLE_TOP    = 10'd20;
  localparam logic [9:0] TABLE_BOTTOM = 10'd460;
  localparam logic [9:0] X_INIT_DEF   = 10'd100;
  localparam logic [9:0] Y_INIT_DEF   = 10'd200;
  localparam logic [9:0] V_MAX_DEF    = 10'd15;
  localparam logic [3:0] FRIC_PER_DEF = 4'd8;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_FRIC = 2'd2
  } state_e;

  function automatic logic [9:0] sat_speed(input logic [9:0] v, input logic [9:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/ball_kinematics_axis_stepper.sv
// One axis of ball motion: position, direction, speed and per-frame step counter.
// Steps one pixel per enabled cycle, reflecting at the cushion limits.
module ball_kinematics_axis_stepper
  import ball_kinematics_pkg::*;
#(
  parameter logic [9:0] POS_INIT = 10'd0,
  parameter logic [9:0] POS_MIN  = 10'd0,
  parameter logic [9:0] POS_MAX  = 10'd1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       upd_i,
  input  logic [9:0] upd_v_i,
  input  logic       upd_dir_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       fric_i,
  output logic [9:0] pos_o,
  output logic       dir_o,
  output logic [9:0] v_o,
  output logic [9:0] cnt_o,
  output logic       bounce_o
);

  logic [9:0] pos_q, pos_d;
  logic       dir_q, dir_d;
  logic [9:0] v_q, v_d;
  logic [9:0] cnt_q, cnt_d;
  logic       at_lim;
  logic       active;
  logic       dir_nxt;

  assign at_lim   = (dir_q == DIR_POS) ? (pos_q == POS_MAX) : (pos_q == POS_MIN);
  assign active   = step_i && (cnt_q != 10'd0);
  assign bounce_o = active && at_lim;
  assign dir_nxt  = dir_q ^ at_lim;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (upd_i) begin
      v_d   = upd_v_i;
      dir_d = upd_dir_i;
    end
    // A same-cycle update takes effect for the frame being loaded.
    if (load_i) cnt_d = upd_i ? upd_v_i : v_q;
    if (active) begin
      dir_d = dir_nxt;
      pos_d = (dir_nxt == DIR_POS) ? pos_q + 10'd1 : pos_q - 10'd1;
      cnt_d = cnt_q - 10'd1;
    end
    if (fric_i && (v_q != 10'd0)) v_d = v_q - 10'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= POS_INIT;
      dir_q <= DIR_POS;
      v_q   <= 10'd0;
      cnt_q <= 10'd0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign pos_o = pos_q;
  assign dir_o = dir_q;
  assign v_o   = v_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/ball_kinematics.sv
// Per-ball motion engine: per-frame pixel stepping with cushion reflection and friction decay.
// Updates are accepted only between frames (upd_ready_o high in S_IDLE).
module ball_kinematics
  import ball_kinematics_pkg::*;
#(
  parameter logic [9:0] X_INIT   = X_INIT_DEF,
  parameter logic [9:0] Y_INIT   = Y_INIT_DEF,
  parameter logic [9:0] X_MIN    = TABLE_LEFT,
  parameter logic [9:0] X_MAX    = TABLE_RIGHT - BALL_SIZE,
  parameter logic [9:0] Y_MIN    = TABLE_TOP,
  parameter logic [9:0] Y_MAX    = TABLE_BOTTOM - BALL_SIZE,
  parameter logic [9:0] V_MAX    = V_MAX_DEF,
  parameter logic [3:0] FRIC_PER = FRIC_PER_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       upd_valid_i,
  output logic       upd_ready_o,
  input  logic [9:0] upd_vx_i,
  input  logic [9:0] upd_vy_i,
  input  logic       upd_dx_i,
  input  logic       upd_dy_i,
  output logic [9:0] x_ball_o,
  output logic [9:0] y_ball_o,
  output logic [9:0] vx_now_o,
  output logic [9:0] vy_now_o,
  output logic       dx_now_o,
  output logic       dy_now_o,
  output logic       moving_o,
  output logic       wall_hit_o,
  output logic       tick_miss_o
);

  state_e     state_q;
  logic [3:0] fric_cnt_q;
  logic       wall_hit_q, tick_miss_q;

  logic       accept, tick_go, fric_dec;
  logic [9:0] sat_vx, sat_vy, eff_vx, eff_vy;
  logic [9:0] cnt_x, cnt_y;
  logic       bounce_x, bounce_y;

  assign upd_ready_o = (state_q == S_IDLE);
  assign accept      = upd_valid_i && upd_ready_o;
  assign tick_go     = frame_tick_i && upd_ready_o;
  assign sat_vx      = sat_speed(upd_vx_i, V_MAX);
  assign sat_vy      = sat_speed(upd_vy_i, V_MAX);
  assign eff_vx      = accept ? sat_vx : vx_now_o;
  assign eff_vy      = accept ? sat_vy : vy_now_o;
  assign fric_dec    = (state_q == S_FRIC) && (fric_cnt_q == FRIC_PER - 4'd1);
  assign moving_o    = (vx_now_o != 10'd0) || (vy_now_o != 10'd0);

  ball_kinematics_axis_stepper #(.POS_INIT(X_INIT), .POS_MIN(X_MIN), .POS_MAX(X_MAX)) u_x (
    .clk_i(clk_i), .rst_i(rst_i), .upd_i(accept), .upd_v_i(sat_vx), .upd_dir_i(upd_dx_i),
    .load_i(tick_go), .step_i(state_q == S_STEP), .fric_i(fric_dec),
    .pos_o(x_ball_o), .dir_o(dx_now_o), .v_o(vx_now_o), .cnt_o(cnt_x), .bounce_o(bounce_x)
  );

  ball_kinematics_axis_stepper #(.POS_INIT(Y_INIT), .POS_MIN(Y_MIN), .POS_MAX(Y_MAX)) u_y (
    .clk_i(clk_i), .rst_i(rst_i), .upd_i(accept), .upd_v_i(sat_vy), .upd_dir_i(upd_dy_i),
    .load_i(tick_go), .step_i(state_q == S_STEP), .fric_i(fric_dec),
    .pos_o(y_ball_o), .dir_o(dy_now_o), .v_o(vy_now_o), .cnt_o(cnt_y), .bounce_o(bounce_y)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fric_cnt_q  <= 4'd0;
      wall_hit_q  <= 1'b0;
      tick_miss_q <= 1'b0;
    end else begin
      wall_hit_q  <= bounce_x || bounce_y;
      tick_miss_q <= frame_tick_i && !upd_ready_o;
      case (state_q)
        S_IDLE: if (tick_go) state_q <= ((eff_vx | eff_vy) != 10'd0) ? S_STEP : S_FRIC;
        // Leave once the step taken this cycle drains both counters.
        S_STEP: if ((cnt_x <= 10'd1) && (cnt_y <= 10'd1)) state_q <= S_FRIC;
        S_FRIC: begin
          state_q <= S_IDLE;
          if (!moving_o || fric_dec) fric_cnt_q <= 4'd0;
          else                       fric_cnt_q <= fric_cnt_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wall_hit_o  = wall_hit_q;
  assign tick_miss_o = tick_miss_q;

endmodule

// File: tb/tb_ball_kinematics.sv
// Randomised and directed checks of ball_kinematics against a frame-level motion model.
module tb_ball_kinematics;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0, upd_valid_i = 1'b0;
  logic       upd_ready_o;
  logic [9:0] upd_vx_i = '0, upd_vy_i = '0;
  logic       upd_dx_i = 1'b0, upd_dy_i = 1'b0;
  logic [9:0] x_ball_o, y_ball_o, vx_now_o, vy_now_o;
  logic       dx_now_o, dy_now_o, moving_o, wall_hit_o, tick_miss_o;

  ball_kinematics dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_tick_i(frame_tick_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_vx_i(upd_vx_i), .upd_vy_i(upd_vy_i), .upd_dx_i(upd_dx_i), .upd_dy_i(upd_dy_i),
    .x_ball_o(x_ball_o), .y_ball_o(y_ball_o), .vx_now_o(vx_now_o), .vy_now_o(vy_now_o),
    .dx_now_o(dx_now_o), .dy_now_o(dy_now_o), .moving_o(moving_o),
    .wall_hit_o(wall_hit_o), .tick_miss_o(tick_miss_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nerr = 0;

  // Behavioural ball model
  int m_x, m_y, m_vx, m_vy, m_fric;
  bit m_dx, m_dy;
  int exp_wh, exp_cycles;
  bit [19:0] exp_trace[$];

  int obs_wh, obs_tm, obs_cycles;
  bit [19:0] obs_trace[$];

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [42:0] exp_state();
    logic [9:0] ex, ey, evx, evy;
    ex = m_x[9:0]; ey = m_y[9:0]; evx = m_vx[9:0]; evy = m_vy[9:0];
    return {ex, ey, evx, evy, m_dx, m_dy, (m_vx != 0 || m_vy != 0)};
  endfunction

  function automatic logic [42:0] obs_state();
    return {x_ball_o, y_ball_o, vx_now_o, vy_now_o, dx_now_o, dy_now_o, moving_o};
  endfunction

  task automatic model_reset();
    m_x = 100; m_y = 200; m_vx = 0; m_vy = 0; m_dx = 1; m_dy = 1; m_fric = 0;
  endtask

  task automatic model_frame();
    int n, cx, cy;
    bit flip;
    cx = m_vx; cy = m_vy;
    n = (m_vx > m_vy) ? m_vx : m_vy;
    exp_trace.delete();
    exp_wh = 0;
    for (int i = 0; i < n; i++) begin
      flip = 0;
      if (cx > 0) begin
        if ((m_dx && m_x == 590) || (!m_dx && m_x == 20)) begin m_dx = !m_dx; flip = 1; end
        m_x = m_dx ? m_x + 1 : m_x - 1;
        cx--;
      end
      if (cy > 0) begin
        if ((m_dy && m_y == 430) || (!m_dy && m_y == 20)) begin m_dy = !m_dy; flip = 1; end
        m_y = m_dy ? m_y + 1 : m_y - 1;
        cy--;
      end
      if (flip) exp_wh++;
      exp_trace.push_back({m_x[9:0], m_y[9:0]});
    end
    exp_cycles = n + 2;
    if (m_vx != 0 || m_vy != 0) begin
      if (m_fric == 7) begin
        m_fric = 0;
        if (m_vx > 0) m_vx--;
        if (m_vy > 0) m_vy--;
      end else m_fric++;
    end else m_fric = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; frame_tick_i = 1'b0; upd_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic apply_upd(input int vx, input int vy, input bit dx, input bit dy);
    upd_valid_i = 1'b1; upd_vx_i = vx[9:0]; upd_vy_i = vy[9:0]; upd_dx_i = dx; upd_dy_i = dy;
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    m_vx = sat(vx); m_vy = sat(vy); m_dx = dx; m_dy = dy;
  endtask

  // Tick one frame (optionally with a same-cycle update); miss_at>0 injects a tick+update mid-frame.
  task automatic run_frame(input bit do_upd, input int uvx, input int uvy,
                           input bit udx, input bit udy, input int miss_at);
    int cyc;
    bit done;
    if (do_upd) begin m_vx = sat(uvx); m_vy = sat(uvy); m_dx = udx; m_dy = udy; end
    model_frame();
    obs_trace.delete(); obs_wh = 0; obs_tm = 0;
    frame_tick_i = 1'b1; upd_valid_i = do_upd;
    upd_vx_i = uvx[9:0]; upd_vy_i = uvy[9:0]; upd_dx_i = udx; upd_dy_i = udy;
    cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk_i);
      cyc++;
      frame_tick_i = (cyc == miss_at);
      upd_valid_i  = (cyc == miss_at);
      upd_vx_i = 10'd7; upd_vy_i = 10'd9; upd_dx_i = 1'b0; upd_dy_i = 1'b0;
      obs_wh += wall_hit_o;
      obs_tm += tick_miss_o;
      if (upd_ready_o) done = 1;
      else begin
        if (cyc >= 2) obs_trace.push_back({x_ball_o, y_ball_o});
        if (cyc > 100) begin done = 1; cyc = -1; end
      end
    end
    frame_tick_i = 1'b0; upd_valid_i = 1'b0;
    obs_cycles = cyc;
  endtask

  task automatic drive_to(input int tx, input int ty);
    int guard = 0;
    while ((m_x != tx || m_y != ty) && guard < 100) begin
      int dxv = (tx > m_x) ? tx - m_x : m_x - tx;
      int dyv = (ty > m_y) ? ty - m_y : m_y - ty;
      run_frame(1, sat(dxv), sat(dyv), tx >= m_x, ty >= m_y, 0);
      guard++;
      nvec++;
      if (obs_state() !== exp_state() || obs_cycles != exp_cycles) begin
        nerr++;
        $display("FAIL drive_to: state %h cyc %0d, want %h cyc %0d", obs_state(), obs_cycles, exp_state(), exp_cycles);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({obs_state(), upd_ready_o, wall_hit_o, tick_miss_o} !== {10'd100, 10'd200, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: got %h rdy %b wh %b tm %b", obs_state(), upd_ready_o, wall_hit_o, tick_miss_o);
    end
    run_frame(0, 0, 0, 0, 0, 0);
    nvec++;
    if (x_ball_o !== 10'd100 || y_ball_o !== 10'd200 || moving_o !== 1'b0 || obs_cycles != 2) begin
      nerr++;
      $display("FAIL idle_tick: x %0d y %0d mv %b cyc %0d, want 100 200 0 2", x_ball_o, y_ball_o, moving_o, obs_cycles);
    end
  endtask

  task automatic test_step();
    apply_upd(5, 0, 1, 1);
    nvec++;
    if (vx_now_o !== 10'd5 || dx_now_o !== 1'b1) begin
      nerr++; $display("FAIL upd_latch: vx %0d dx %b, want 5 1", vx_now_o, dx_now_o);
    end
    run_frame(0, 0, 0, 0, 0, 0);
    nvec++;
    if (x_ball_o !== 10'd105 || obs_cycles != 7 || obs_trace.size() != 5) begin
      nerr++; $display("FAIL step5: x %0d cyc %0d steps %0d, want 105 7 5", x_ball_o, obs_cycles, obs_trace.size());
    end
  endtask

  task automatic test_bounce();
    int want[5] = '{589, 590, 589, 588, 587};
    bit bad = 0;
    drive_to(588, m_y);
    run_frame(1, 5, 0, 1, 1, 0);
    if (obs_trace.size() != 5) bad = 1;
    else foreach (want[i]) if (int'(obs_trace[i][19:10]) != want[i]) bad = 1;
    nvec++;
    if (bad || dx_now_o !== 1'b0 || obs_wh != 1) begin
      nerr++; $display("FAIL right_bounce: x %0d dx %b wh %0d steps %0d, want 587 0 1 5", x_ball_o, dx_now_o, obs_wh, obs_trace.size());
    end
  endtask

  task automatic test_friction();
    do_reset();
    apply_upd(3, 0, 1, 1);
    for (int t = 1; t <= 24; t++) begin
      run_frame(0, 0, 0, 0, 0, 0);
      if (t == 7 || t == 8 || t == 16 || t == 24) begin
        int want = (t == 7) ? 3 : (t == 8) ? 2 : (t == 16) ? 1 : 0;
        nvec++;
        if (int'(vx_now_o) != want || moving_o !== (want != 0)) begin
          nerr++; $display("FAIL friction_t%0d: vx %0d mv %b, want %0d", t, vx_now_o, moving_o, want);
        end
      end
    end
    nvec++;
    if (obs_state() !== exp_state()) begin
      nerr++; $display("FAIL friction_pos: %h want %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_saturate_miss();
    apply_upd(40, 0, 1, 1);
    nvec++;
    if (vx_now_o !== 10'd15) begin
      nerr++; $display("FAIL saturate: vx %0d want 15", vx_now_o);
    end
    run_frame(0, 0, 0, 0, 0, 3);
    nvec++;
    if (obs_tm != 1 || obs_state() !== exp_state() || obs_cycles != 17) begin
      nerr++; $display("FAIL tick_miss: tm %0d state %h cyc %0d, want 1 %h 17", obs_tm, obs_state(), obs_cycles, exp_state());
    end
  endtask

  task automatic test_same_cycle_corner();
    int x0 = m_x;
    run_frame(1, 2, 0, 1, 1, 0);
    nvec++;
    if (int'(x_ball_o) != x0 + 2 || obs_cycles != 4) begin
      nerr++; $display("FAIL same_cycle_upd: x %0d cyc %0d, want %0d 4", x_ball_o, obs_cycles, x0 + 2);
    end
    drive_to(590, 430);
    run_frame(1, 1, 1, 1, 1, 0);
    nvec++;
    if (x_ball_o !== 10'd589 || y_ball_o !== 10'd429 || dx_now_o !== 1'b0 || dy_now_o !== 1'b0 || obs_wh != 1) begin
      nerr++; $display("FAIL corner: x %0d y %0d dx %b dy %b wh %0d, want 589 429 0 0 1", x_ball_o, y_ball_o, dx_now_o, dy_now_o, obs_wh);
    end
  endtask

  task automatic test_reset_midstep();
    frame_tick_i = 1'b1; upd_valid_i = 1'b1; upd_vx_i = 10'd10; upd_vy_i = 10'd10;
    upd_dx_i = 1'b0; upd_dy_i = 1'b0;
    @(negedge clk_i);
    frame_tick_i = 1'b0; upd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    nvec++;
    if ({obs_state(), upd_ready_o, wall_hit_o} !== {exp_state(), 1'b1, 1'b0}) begin
      nerr++; $display("FAIL reset_midstep: %h rdy %b want %h rdy 1", obs_state(), upd_ready_o, exp_state());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 150; f++) begin
      bit bad;
      if ($urandom_range(0, 3) == 0)
        apply_upd($urandom_range(0, 40), $urandom_range(0, 40), 1'($urandom), 1'($urandom));
      run_frame(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 40),
                1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0) ? 2 : 0);
      bad = (obs_trace.size() != exp_trace.size());
      if (!bad) foreach (exp_trace[i]) if (obs_trace[i] !== exp_trace[i]) bad = 1;
      nvec++;
      if (bad || obs_state() !== exp_state() || obs_wh != exp_wh || obs_cycles != exp_cycles) begin
        nerr++;
        $display("FAIL random_f%0d: state %h wh %0d cyc %0d trace_ok %b, want %h wh %0d cyc %0d",
                 f, obs_state(), obs_wh, obs_cycles, !bad, exp_state(), exp_wh, exp_cycles);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_bounce();
    test_friction();
    test_saturate_miss();
    test_same_cycle_corner();
    test_reset_midstep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
